// File: rtl/instr_fetch_reg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_reg
// Brief    : Single-word instruction fetch with timeout, IR and field decode.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_reg #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_fetch_start,
  input  logic [31:0] i_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_ir_valid,
  output logic        o_fetch_err,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_funct,
  output logic [15:0] o_imm,
  output logic [25:0] o_target
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Last counter value before an unacknowledged request aborts.
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_ir;
  logic [31:0] r_mem_addr;
  logic        r_ir_valid;
  logic        r_fetch_err;

  logic        w_in_req;
  logic        w_accept;
  logic        w_aligned;
  logic        w_capture;
  logic        w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_in_req  = 1'b0;
    w_accept  = 1'b0;
    w_aligned = (i_pc[1:0] == 2'b00);
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_REQ: begin
        w_in_req = 1'b1;
        if (i_mem_ack) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end else if (r_cnt == c_tmo_last) begin
          w_timeout = 1'b1;
          w_next    = S_ERR;
        end
      end
      default: begin
        if (i_fetch_start) begin
          w_accept = 1'b1;
          w_next   = w_aligned ? S_REQ : S_ERR;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 8'd0;
      r_ir        <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_ir_valid  <= 1'b0;
      r_fetch_err <= 1'b0;
    end else if (w_accept) begin
      r_ir_valid <= 1'b0;
      if (w_aligned) begin
        r_mem_addr  <= i_pc;
        r_cnt       <= 8'd0;
        r_fetch_err <= 1'b0;
      end else begin
        r_fetch_err <= 1'b1;
      end
    end else if (w_capture) begin
      r_ir       <= i_mem_rdata;
      r_ir_valid <= 1'b1;
    end else if (w_timeout) begin
      r_fetch_err <= 1'b1;
    end else if (w_in_req) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_mem_req   = w_in_req;
  assign o_busy      = w_in_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_ir_valid  = r_ir_valid;
  assign o_fetch_err = r_fetch_err;

  assign o_opcode = r_ir[31:26];
  assign o_rs     = r_ir[25:21];
  assign o_rt     = r_ir[20:16];
  assign o_rd     = r_ir[15:11];
  assign o_shamt  = r_ir[10:6];
  assign o_funct  = r_ir[5:0];
  assign o_imm    = r_ir[15:0];
  assign o_target = r_ir[25:0];

endmodule
`default_nettype wire

// File: doc/instr_fetch_reg.md
INSTR_FETCH_REG -- requirements
Module: instr_fetch_reg

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles mem_req stays high awaiting mem_ack before a fetch aborts (legal range 2..255).
REQ-002 clk  input  1  rising-edge system clock; only clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 fetch_start  input  1  control FSM request to fetch the word at pc; sampled on rising edge.
REQ-005 pc  input  32  byte address of instruction; sampled when fetch_start is accepted.
REQ-006 mem_req  output  1  memory read request.
REQ-007 mem_addr  output  32  address latched at fetch acceptance.
REQ-008 mem_ack  input  1  memory read completion; mem_rdata valid in the same cycle.
REQ-009 mem_rdata  input  32  instruction word from memory.
REQ-010 busy  output  1  high while a fetch is outstanding (state REQ).
REQ-011 ir_valid  output  1  instruction register holds a word from the latest completed fetch.
REQ-012 fetch_err  output  1  latest fetch aborted (misaligned pc or timeout).
REQ-013 opcode[31:26] 6, rs[25:21] 5, rt[20:16] 5, rd[15:11] 5, shamt[10:6] 5, funct[5:0] 6, imm[15:0] 16, target[25:0] 26: outputs, fixed bit-slices of the internal 32-bit IR; imm drives the zero/sign-extend units directly.

Function
REQ-014 States: IDLE, REQ, DONE, ERR; registered state, one-hot or binary at implementer's choice.
REQ-015 IDLE/DONE/ERR with fetch_start=1 and pc[1:0]==0: next state REQ; mem_addr<=pc; timeout counter<=0; ir_valid<=0; fetch_err<=0.
REQ-016 IDLE/DONE/ERR with fetch_start=1 and pc[1:0]!=0: next state ERR; fetch_err<=1; ir_valid<=0; no mem_req issued; IR unchanged.
REQ-017 REQ: mem_req=1 and busy=1 (decoded from state); fetch_start ignored.
REQ-018 REQ with mem_ack=1: IR<=mem_rdata; next state DONE; ir_valid<=1.
REQ-019 REQ with mem_ack=0: counter increments; when counter==TIMEOUT-1 and no ack, next state ERR, fetch_err<=1; mem_req therefore high exactly TIMEOUT cycles.
REQ-020 Ack on the final timeout cycle wins: capture word, go DONE, no error.
REQ-021 mem_ack in IDLE/DONE/ERR ignored; IR unchanged.
REQ-022 Latency: fetch_start sampled at edge E0 -> mem_req high after E0; ack sampled at edge Ek -> IR fields and ir_valid updated after Ek; zero-wait memory (ack in first REQ cycle) gives ir_valid after E1.
REQ-023 IR holds its value through DONE, ERR and subsequent REQ until a new ack; decoded fields are pure slices, no extra latency.
REQ-024 ir_valid and fetch_err never both high; both stay stable until next accepted fetch_start or reset.
REQ-025 Back-to-back: fetch_start in DONE on the edge leaving DONE starts the next fetch with no idle cycle.

Reset
REQ-026 rst_n=0 immediately, without clock: state IDLE, mem_req=0, busy=0, ir_valid=0, fetch_err=0, mem_addr=0, IR=0 (all fields 0), counter=0.
REQ-027 Reset mid-REQ abandons the fetch; a late mem_ack after reset release is ignored per REQ-021.
REQ-028 First accepted fetch_start is the first rising edge with rst_n=1 already high.

Verification
REQ-029 Reset, then pc=0x00000040 with fetch_start, mem_ack one cycle later with rdata=0x3C081234 -> mem_addr=0x40, mem_req 2 cycles, ir_valid=1, opcode=0x0F, rt=8, imm=0x1234.
REQ-030 pc=0x00000042 with fetch_start -> mem_req never asserts, fetch_err=1 next cycle, IR keeps prior 0x3C081234.
REQ-031 TIMEOUT=16, no ack -> mem_req high exactly 16 cycles, then fetch_err=1, ir_valid=0; ack on 16th cycle instead -> DONE, fetch_err=0.
REQ-032 Zero-wait memory, fetch_start held high continuously from DONE, rdata 0x00000020, 0x8C220004 -> fetch every 2 cycles; funct=0x20 then opcode=0x23, imm=0x0004.
REQ-033 rst_n low for 1 ns mid-REQ between edges -> mem_req and busy drop before next edge, IR=0; spurious mem_ack afterwards leaves ir_valid=0.
REQ-034 fetch_start pulsed during REQ -> ignored; single fetch completes with original mem_addr.
